// File: rtl/csr_regblock_pkg.sv
// csr_regblock_pkg: shared types and constants for the CSR register block.
// Contents: FSM state type, register word offsets, CTRL/STATUS field layout.
package csr_regblock_pkg;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    // Word offsets, decoded from bus_addr[3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_SCRATCH = 2'd2;
    localparam logic [1:0] REG_COUNTER = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_CLR      = 1;
    localparam int CTRL_MASK_LSB = 8;
    localparam int CTRL_MASK_MSB = 15;

    localparam int STATUS_W = 8;

endpackage

// File: rtl/csr_sat_counter.sv
// csr_sat_counter: event counter that saturates at all-ones; clear beats increment.
// Ports: clk, rst (async, active-high), en, clr, inc -> cnt[W-1:0].
module csr_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/csr_regblock.sv
// csr_regblock: CTRL/STATUS(W1C)/SCRATCH/COUNTER registers behind a req/ready bus.
// Ports: bus_* request/response, hw_ctrl, hw_status_set, hw_event, irq.
module csr_regblock
    import csr_regblock_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_req,
    input  logic                    bus_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    input  logic [DATA_WIDTH-1:0]   bus_wr_data,
    input  logic [DATA_WIDTH/8-1:0] bus_wr_biten,
    output logic                    bus_ready,
    output logic [DATA_WIDTH-1:0]   bus_rd_data,
    output logic                    bus_err,
    output logic [DATA_WIDTH-1:0]   hw_ctrl,
    input  logic [STATUS_W-1:0]     hw_status_set,
    input  logic                    hw_event,
    output logic                    irq
);

    localparam int NB = DATA_WIDTH / 8;

    state_t                state;
    logic [DATA_WIDTH-1:0] ctrl_q;
    logic [DATA_WIDTH-1:0] scratch_q;
    logic [STATUS_W-1:0]   status_q;
    logic [CNT_WIDTH-1:0]  cnt;

    logic [1:0]            sel;
    logic                  aligned;
    logic                  mapped;
    logic                  acc;
    logic                  err_n;
    logic                  wr_en;
    logic                  hit_ctrl;
    logic                  hit_status;
    logic                  hit_scratch;
    logic                  hit_counter;
    logic                  cnt_clr;
    logic [DATA_WIDTH-1:0] bmask;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] ctrl_wr;
    logic [STATUS_W-1:0]   w1c;

    assign sel     = bus_addr[3:2];
    assign aligned = (bus_addr[1:0] == 2'b00);

    // Any address above the four word registers is unmapped
    if (ADDR_WIDTH > 4) begin : g_hi
        assign mapped = ~|bus_addr[ADDR_WIDTH-1:4];
    end else begin : g_lo
        assign mapped = 1'b1;
    end

    assign hit_ctrl    = (sel == REG_CTRL);
    assign hit_status  = (sel == REG_STATUS);
    assign hit_scratch = (sel == REG_SCRATCH);
    assign hit_counter = (sel == REG_COUNTER);

    // Access executes only on the IDLE->RESP transition
    assign acc   = (state == IDLE) && bus_req;
    assign err_n = !aligned || !mapped
                 || (bus_req_is_wr && hit_counter);
    assign wr_en = acc && bus_req_is_wr && !err_n;

    assign cnt_clr = wr_en && hit_ctrl
                   && bus_wr_biten[0]
                   && bus_wr_data[CTRL_CLR];

    assign w1c = (wr_en && hit_status && bus_wr_biten[0])
               ? bus_wr_data[STATUS_W-1:0] : '0;

    assign hw_ctrl = ctrl_q;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < NB; b++) begin
            bmask[b*8 +: 8] = {8{bus_wr_biten[b]}};
        end
    end

    // CTRL clear bit is a pulse, never stored
    always_comb begin
        ctrl_wr           = (ctrl_q & ~bmask) | (bus_wr_data & bmask);
        ctrl_wr[CTRL_CLR] = 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            hit_ctrl:    rd_mux = ctrl_q;
            hit_status:  rd_mux = DATA_WIDTH'(status_q);
            hit_scratch: rd_mux = scratch_q;
            hit_counter: rd_mux = DATA_WIDTH'(cnt);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            status_q  <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_en && hit_ctrl) begin
                ctrl_q <= ctrl_wr;
            end
            if (wr_en && hit_scratch) begin
                scratch_q <= (scratch_q & ~bmask)
                           | (bus_wr_data & bmask);
            end
            // hw set wins over a same-cycle W1C
            status_q <= (status_q & ~w1c) | hw_status_set;
            irq      <= |(status_q
                        & ctrl_q[CTRL_MASK_MSB:CTRL_MASK_LSB]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus_ready   <= 1'b0;
            bus_err     <= 1'b0;
            bus_rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_req) begin
                        state       <= RESP;
                        bus_ready   <= 1'b1;
                        bus_err     <= err_n;
                        bus_rd_data <= (!bus_req_is_wr && !err_n)
                                     ? rd_mux : '0;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    bus_ready   <= 1'b0;
                    bus_err     <= 1'b0;
                    bus_rd_data <= '0;
                end
            endcase
        end
    end

    csr_sat_counter #(
        .W(CNT_WIDTH)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .en (ctrl_q[CTRL_EN]),
        .clr(cnt_clr),
        .inc(hw_event),
        .cnt(cnt)
    );

endmodule

// File: tb/tb_csr_regblock.sv
// tb_csr_regblock: directed scenarios plus randomized traffic for csr_regblock.
// A cycle-level register model predicts every bus response, irq and hw_ctrl.
module tb_csr_regblock;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_req_is_wr = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wr_data = '0;
    logic [3:0]  bus_wr_biten = '0;
    logic        bus_ready;
    logic [31:0] bus_rd_data;
    logic        bus_err;
    logic [31:0] hw_ctrl;
    logic [7:0]  hw_status_set = '0;
    logic        hw_event = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    csr_regblock #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(32),
        .CNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_req      (bus_req),
        .bus_req_is_wr(bus_req_is_wr),
        .bus_addr     (bus_addr),
        .bus_wr_data  (bus_wr_data),
        .bus_wr_biten (bus_wr_biten),
        .bus_ready    (bus_ready),
        .bus_rd_data  (bus_rd_data),
        .bus_err      (bus_err),
        .hw_ctrl      (hw_ctrl),
        .hw_status_set(hw_status_set),
        .hw_event     (hw_event),
        .irq          (irq)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_ctrl, m_scratch, m_rd;
    logic [7:0]  m_status;
    logic [15:0] m_cnt;
    logic        m_irq, m_busy, m_ready, m_err;

    logic [31:0] last_rd;
    logic        last_rdy, last_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_scratch = '0; m_status = '0; m_cnt = '0;
        m_irq = 0; m_busy = 0; m_ready = 0; m_err = 0; m_rd = '0;
    endtask

    // Predict one clock from current inputs, advance, then compare
    task automatic step();
        logic [31:0] mask, n_ctrl, n_scratch, rd;
        logic [7:0]  n_status, w1c;
        logic [15:0] n_cnt;
        logic        start, err, doit, wr, clr;
        int          r;
        if (rst) begin
            @(posedge clk); #1;
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++)
                mask[i*8 +: 8] = bus_wr_biten[i] ? 8'hFF : 8'h00;
            start = bus_req && !m_busy;
            wr    = bus_req_is_wr;
            r     = int'(bus_addr[3:2]);
            err   = start && ((bus_addr[1:0] != 0) || (wr && r == 3));
            doit  = start && !err;
            rd    = '0;
            if (doit && !wr) begin
                case (r)
                    0: rd = m_ctrl;
                    1: rd = {24'h0, m_status};
                    2: rd = m_scratch;
                    default: rd = {16'h0, m_cnt};
                endcase
            end
            n_ctrl = m_ctrl;
            if (doit && wr && r == 0)
                n_ctrl = ((m_ctrl & ~mask) | (bus_wr_data & mask))
                       & ~32'h2;
            n_scratch = m_scratch;
            if (doit && wr && r == 2)
                n_scratch = (m_scratch & ~mask) | (bus_wr_data & mask);
            clr = doit && wr && r == 0 && bus_wr_biten[0]
                && bus_wr_data[1];
            if (clr)
                n_cnt = 0;
            else if (m_ctrl[0] && hw_event && m_cnt != 16'hFFFF)
                n_cnt = m_cnt + 1;
            else
                n_cnt = m_cnt;
            w1c = (doit && wr && r == 1 && bus_wr_biten[0])
                ? bus_wr_data[7:0] : 8'h0;
            n_status = (m_status & ~w1c) | hw_status_set;
            @(posedge clk); #1;
            m_irq     = |(m_status & m_ctrl[15:8]);
            m_ctrl    = n_ctrl;
            m_scratch = n_scratch;
            m_status  = n_status;
            m_cnt     = n_cnt;
            m_busy    = start;
            m_ready   = start;
            m_err     = err;
            m_rd      = rd;
        end
        chk("ready",   {31'b0, bus_ready}, {31'b0, m_ready});
        chk("rd_data", bus_rd_data,        m_rd);
        chk("err",     {31'b0, bus_err},   {31'b0, m_err});
        chk("irq",     {31'b0, irq},       {31'b0, m_irq});
        chk("hw_ctrl", hw_ctrl,            m_ctrl);
    endtask

    task automatic rand_hw();
        hw_event      = 1'($urandom_range(0, 1));
        hw_status_set = ($urandom_range(0, 3) == 0)
                      ? 8'($urandom) : 8'h00;
    endtask

    task automatic xact(input logic wr, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input bit rnd);
        bus_req = 1; bus_req_is_wr = wr; bus_addr = a;
        bus_wr_data = d; bus_wr_biten = be;
        if (rnd) rand_hw();
        step();
        last_rdy = bus_ready; last_rd = bus_rd_data; last_err = bus_err;
        if (rnd) rand_hw();
        step();
        bus_req = 0;
    endtask

    logic [31:0] cnt_before;

    initial begin
        model_reset();
        repeat (3) step();
        rst = 0;
        step();

        // Scratch write and readback
        xact(1, 4'h8, 32'hA5A5_0301, 4'hF, 0);
        xact(0, 4'h8, 32'h0, 4'h0, 0);
        chk("t1_rdy", {31'b0, last_rdy}, 32'h1);
        chk("t1_rd",  last_rd, 32'hA5A5_0301);
        chk("t1_err", {31'b0, last_err}, 32'h0);

        // Byte-lane write
        xact(1, 4'h8, 32'h0, 4'hF, 0);
        xact(1, 4'h8, 32'hFFFF_FFFF, 4'h2, 0);
        xact(0, 4'h8, 32'h0, 4'h0, 0);
        chk("t2_rd", last_rd, 32'h0000_FF00);
        xact(1, 4'h8, 32'hDEAD_BEEF, 4'h0, 0);
        chk("t2_noop_err", {31'b0, last_err}, 32'h0);
        xact(0, 4'h8, 32'h0, 4'h0, 0);
        chk("t2_noop_rd", last_rd, 32'h0000_FF00);

        // Status set, masked irq, W1C
        xact(1, 4'h0, 32'h0000_0400, 4'hF, 0);
        hw_status_set = 8'h05;
        step();
        hw_status_set = 8'h00;
        step();
        chk("t3_irq", {31'b0, irq}, 32'h1);
        xact(1, 4'h4, 32'h0000_0004, 4'hF, 0);
        chk("t3_irq_clr", {31'b0, irq}, 32'h0);
        xact(0, 4'h4, 32'h0, 4'h0, 0);
        chk("t3_status", last_rd, 32'h0000_0001);

        // Counter enable, events, clear vs event
        xact(1, 4'h0, 32'h0000_0001, 4'hF, 0);
        hw_event = 1;
        repeat (3) step();
        hw_event = 0;
        xact(0, 4'hC, 32'h0, 4'h0, 0);
        chk("t4_cnt", last_rd, 32'h3);
        bus_req = 1; bus_req_is_wr = 1; bus_addr = 4'h0;
        bus_wr_data = 32'h3; bus_wr_biten = 4'hF; hw_event = 1;
        step();
        hw_event = 0;
        step();
        bus_req = 0;
        xact(0, 4'hC, 32'h0, 4'h0, 0);
        chk("t4_clr", last_rd, 32'h0);
        xact(0, 4'h0, 32'h0, 4'h0, 0);
        chk("t4_ctrl", last_rd, 32'h0000_0001);

        // Errors: write to RO counter, unaligned access
        hw_event = 1;
        step(); step();
        hw_event = 0;
        xact(0, 4'hC, 32'h0, 4'h0, 0);
        cnt_before = last_rd;
        xact(1, 4'hC, 32'hFFFF, 4'hF, 0);
        chk("t5_wr_err", {31'b0, last_err}, 32'h1);
        xact(0, 4'h2, 32'h0, 4'h0, 0);
        chk("t5_ua_err", {31'b0, last_err}, 32'h1);
        chk("t5_ua_rd", last_rd, 32'h0);
        xact(1, 4'h9, 32'h1234_5678, 4'hF, 0);
        chk("t5_ua_wr_err", {31'b0, last_err}, 32'h1);
        xact(0, 4'hC, 32'h0, 4'h0, 0);
        chk("t5_cnt_same", last_rd, cnt_before);
        xact(0, 4'h8, 32'h0, 4'h0, 0);
        chk("t5_scr_same", last_rd, 32'h0000_FF00);

        // Reset during RESP with request held
        bus_req = 1; bus_req_is_wr = 1; bus_addr = 4'h8;
        bus_wr_data = 32'h1234_5678; bus_wr_biten = 4'hF;
        step();
        chk("t6_rdy", {31'b0, bus_ready}, 32'h1);
        rst = 1;
        #1;
        chk("t6_rdy_rst", {31'b0, bus_ready}, 32'h0);
        chk("t6_err_rst", {31'b0, bus_err}, 32'h0);
        model_reset();
        bus_req = 0;
        step(); step();
        rst = 0;
        step();
        xact(0, 4'h8, 32'h0, 4'h0, 0);
        chk("t6_scr", last_rd, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [3:0] a;
            a = 4'($urandom);
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            xact(1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom), 1);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                rand_hw();
                step();
            end
        end
        hw_event = 0;
        hw_status_set = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
